// File: rtl/net_tx_framer_if.sv
`default_nettype none
// ============================================================================
// Module      : net_tx_framer_if
// Description : Upstream frame stream plus txc/txd streams toward the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface net_tx_framer_if;
    logic [31:0] in_tdata;
    logic [3:0]  in_tkeep;
    logic        in_tlast;
    logic        in_tvalid;
    logic        in_tready;

    logic [31:0] s_axis_txc_tdata;
    logic [3:0]  s_axis_txc_tkeep;
    logic        s_axis_txc_tlast;
    logic        s_axis_txc_tvalid;
    logic        s_axis_txc_tready;

    logic [31:0] s_axis_txd_tdata;
    logic [3:0]  s_axis_txd_tkeep;
    logic        s_axis_txd_tlast;
    logic        s_axis_txd_tvalid;
    logic        s_axis_txd_tready;

    // Framer side
    modport master (
        input  in_tdata, in_tkeep, in_tlast, in_tvalid,
        output in_tready,
        output s_axis_txc_tdata, s_axis_txc_tkeep, s_axis_txc_tlast, s_axis_txc_tvalid,
        input  s_axis_txc_tready,
        output s_axis_txd_tdata, s_axis_txd_tkeep, s_axis_txd_tlast, s_axis_txd_tvalid,
        input  s_axis_txd_tready
    );

    // Upstream source / arbiter side
    modport slave (
        output in_tdata, in_tkeep, in_tlast, in_tvalid,
        input  in_tready,
        input  s_axis_txc_tdata, s_axis_txc_tkeep, s_axis_txc_tlast, s_axis_txc_tvalid,
        output s_axis_txc_tready,
        input  s_axis_txd_tdata, s_axis_txd_tkeep, s_axis_txd_tlast, s_axis_txd_tvalid,
        output s_axis_txd_tready
    );
endinterface
`default_nettype wire

// File: rtl/net_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : net_tx_framer
// Description : Store-and-forward TX framer: buffers one frame, then emits a
//               6-word control frame on txc followed by the payload on txd.
// Revision    : 1.0 - initial release
// ============================================================================
module net_tx_framer #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  wire logic           S_CLK,
    input  wire logic           S_ARESET,
    net_tx_framer_if.master     axis,
    output logic [15:0]         frames_sent,
    output logic [15:0]         frames_dropped,
    output logic                busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_TXC  = 3'd2,
        S_TXD  = 3'd3,
        S_DROP = 3'd4
    } state_t;

    localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
    localparam logic [31:0] C_HDR = 32'hA000_0000;

    state_t      state_q, state_d;
    logic [AW:0] wcnt_q, wcnt_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [2:0]  cidx_q, cidx_d;
    logic        in_tready_q, in_tready_d;
    logic [31:0] txc_tdata_q, txc_tdata_d;
    logic [3:0]  txc_tkeep_q, txc_tkeep_d;
    logic        txc_tlast_q, txc_tlast_d;
    logic        txc_tvalid_q, txc_tvalid_d;
    logic [31:0] txd_tdata_q, txd_tdata_d;
    logic [3:0]  txd_tkeep_q, txd_tkeep_d;
    logic        txd_tlast_q, txd_tlast_d;
    logic        txd_tvalid_q, txd_tvalid_d;
    logic [15:0] sent_q, sent_d;
    logic [15:0] dropped_q, dropped_d;
    logic        busy_q, busy_d;

    logic [35:0] mem [DEPTH];
    logic [35:0] rdata_q;
    logic        wr_en;
    logic        in_acc, txc_hs, txd_hs;

    assign in_acc = axis.in_tvalid & in_tready_q;
    assign txc_hs = txc_tvalid_q & axis.s_axis_txc_tready;
    assign txd_hs = txd_tvalid_q & axis.s_axis_txd_tready;

    // Read address is the next-cycle pointer, so rdata_q always holds the word
    // that the next txd handshake must present (no bubbles).
    always_ff @(posedge S_CLK) begin
        if (wr_en) begin
            mem[wcnt_q[AW-1:0]] <= {axis.in_tkeep, axis.in_tdata};
        end
        rdata_q <= mem[rptr_d[AW-1:0]];
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        rptr_d       = rptr_q;
        cidx_d       = cidx_q;
        txc_tdata_d  = txc_tdata_q;
        txc_tkeep_d  = txc_tkeep_q;
        txc_tlast_d  = txc_tlast_q;
        txc_tvalid_d = txc_tvalid_q;
        txd_tdata_d  = txd_tdata_q;
        txd_tkeep_d  = txd_tkeep_q;
        txd_tlast_d  = txd_tlast_q;
        txd_tvalid_d = txd_tvalid_q;
        sent_d       = sent_q;
        dropped_d    = dropped_q;
        wr_en        = 1'b0;

        case (state_q)
            S_IDLE, S_FILL: begin
                if (in_acc) begin
                    if (wcnt_q == FULL) begin
                        if (dropped_q != 16'hFFFF) begin
                            dropped_d = dropped_q + 16'd1;
                        end
                        wcnt_d  = '0;
                        state_d = axis.in_tlast ? S_IDLE : S_DROP;
                    end else begin
                        wr_en  = 1'b1;
                        wcnt_d = wcnt_q + 1'b1;
                        if (axis.in_tlast) begin
                            state_d      = S_TXC;
                            cidx_d       = 3'd0;
                            rptr_d       = '0;
                            txc_tvalid_d = 1'b1;
                            txc_tdata_d  = C_HDR;
                            txc_tkeep_d  = 4'hF;
                            txc_tlast_d  = 1'b0;
                        end else begin
                            state_d = S_FILL;
                        end
                    end
                end
            end
            S_DROP: begin
                if (in_acc && axis.in_tlast) begin
                    state_d = S_IDLE;
                end
            end
            S_TXC: begin
                if (txc_hs) begin
                    if (cidx_q == 3'd5) begin
                        txc_tvalid_d = 1'b0;
                        txc_tdata_d  = '0;
                        txc_tkeep_d  = '0;
                        txc_tlast_d  = 1'b0;
                        state_d      = S_TXD;
                        txd_tvalid_d = 1'b1;
                        txd_tdata_d  = rdata_q[31:0];
                        txd_tkeep_d  = rdata_q[35:32];
                        txd_tlast_d  = (wcnt_q == (AW+1)'(1));
                        rptr_d       = (AW+1)'(1);
                    end else begin
                        cidx_d      = cidx_q + 3'd1;
                        txc_tdata_d = '0;
                        txc_tlast_d = (cidx_q == 3'd4);
                    end
                end
            end
            S_TXD: begin
                if (txd_hs) begin
                    if (txd_tlast_q) begin
                        txd_tvalid_d = 1'b0;
                        txd_tdata_d  = '0;
                        txd_tkeep_d  = '0;
                        txd_tlast_d  = 1'b0;
                        sent_d       = sent_q + 16'd1;
                        wcnt_d       = '0;
                        rptr_d       = '0;
                        state_d      = S_IDLE;
                    end else begin
                        txd_tdata_d = rdata_q[31:0];
                        txd_tkeep_d = rdata_q[35:32];
                        txd_tlast_d = (rptr_q == wcnt_q - 1'b1);
                        rptr_d      = rptr_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_tready_d = (state_d == S_IDLE) || (state_d == S_FILL) || (state_d == S_DROP);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge S_CLK or posedge S_ARESET) begin
        if (S_ARESET) begin
            state_q      <= S_IDLE;
            wcnt_q       <= '0;
            rptr_q       <= '0;
            cidx_q       <= '0;
            in_tready_q  <= 1'b0;
            txc_tdata_q  <= '0;
            txc_tkeep_q  <= '0;
            txc_tlast_q  <= 1'b0;
            txc_tvalid_q <= 1'b0;
            txd_tdata_q  <= '0;
            txd_tkeep_q  <= '0;
            txd_tlast_q  <= 1'b0;
            txd_tvalid_q <= 1'b0;
            sent_q       <= '0;
            dropped_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            rptr_q       <= rptr_d;
            cidx_q       <= cidx_d;
            in_tready_q  <= in_tready_d;
            txc_tdata_q  <= txc_tdata_d;
            txc_tkeep_q  <= txc_tkeep_d;
            txc_tlast_q  <= txc_tlast_d;
            txc_tvalid_q <= txc_tvalid_d;
            txd_tdata_q  <= txd_tdata_d;
            txd_tkeep_q  <= txd_tkeep_d;
            txd_tlast_q  <= txd_tlast_d;
            txd_tvalid_q <= txd_tvalid_d;
            sent_q       <= sent_d;
            dropped_q    <= dropped_d;
            busy_q       <= busy_d;
        end
    end

    assign axis.in_tready         = in_tready_q;
    assign axis.s_axis_txc_tdata  = txc_tdata_q;
    assign axis.s_axis_txc_tkeep  = txc_tkeep_q;
    assign axis.s_axis_txc_tlast  = txc_tlast_q;
    assign axis.s_axis_txc_tvalid = txc_tvalid_q;
    assign axis.s_axis_txd_tdata  = txd_tdata_q;
    assign axis.s_axis_txd_tkeep  = txd_tkeep_q;
    assign axis.s_axis_txd_tlast  = txd_tlast_q;
    assign axis.s_axis_txd_tvalid = txd_tvalid_q;
    assign frames_sent            = sent_q;
    assign frames_dropped         = dropped_q;
    assign busy                   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_net_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_net_tx_framer
// Description : Scoreboard bench for net_tx_framer (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_net_tx_framer;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic        S_CLK = 1'b0;
    logic        S_ARESET = 1'b1;
    logic [15:0] frames_sent;
    logic [15:0] frames_dropped;
    logic        busy;
    bit          bp_en = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int tlast_cyc = 0;
    int txc0_cyc = 0;
    int txd0_cyc = 0;
    int txd_pops = 0;

    beat_t txc_q[$];
    beat_t txd_q[$];
    beat_t in_beats[$];

    net_tx_framer_if ifc ();

    net_tx_framer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .S_CLK          (S_CLK),
        .S_ARESET       (S_ARESET),
        .axis           (ifc.master),
        .frames_sent    (frames_sent),
        .frames_dropped (frames_dropped),
        .busy           (busy)
    );

    always #5 S_CLK = ~S_CLK;
    always @(posedge S_CLK) cyc <= cyc + 1;

    // txd ready toggles every cycle while backpressure is enabled
    always @(posedge S_CLK) begin
        #1;
        ifc.s_axis_txd_tready = bp_en ? ~ifc.s_axis_txd_tready : 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations on every output handshake, checks hold rule
    bit    hold_c = 0, hold_d = 0, want_d0 = 0;
    beat_t held_c, held_d, act_c, act_d, e;
    always @(negedge S_CLK) begin
        if (S_ARESET) begin
            hold_c = 0;
            hold_d = 0;
            want_d0 = 0;
            txc_q.delete();
            txd_q.delete();
        end else begin
            act_c = {ifc.s_axis_txc_tdata, ifc.s_axis_txc_tkeep, ifc.s_axis_txc_tlast};
            act_d = {ifc.s_axis_txd_tdata, ifc.s_axis_txd_tkeep, ifc.s_axis_txd_tlast};
            if (hold_c) begin
                chk("txc_hold_valid", ifc.s_axis_txc_tvalid, 1);
                chk("txc_hold_data", act_c, held_c);
            end
            if (hold_d) begin
                chk("txd_hold_valid", ifc.s_axis_txd_tvalid, 1);
                chk("txd_hold_data", act_d, held_d);
            end
            hold_c = ifc.s_axis_txc_tvalid && !ifc.s_axis_txc_tready;
            hold_d = ifc.s_axis_txd_tvalid && !ifc.s_axis_txd_tready;
            held_c = act_c;
            held_d = act_d;
            if (ifc.s_axis_txc_tvalid && ifc.s_axis_txd_tvalid)
                chk("txc_txd_both_valid", 1, 0);
            if (ifc.s_axis_txc_tvalid || ifc.s_axis_txd_tvalid)
                chk("in_tready_while_tx", ifc.in_tready, 0);
            if (ifc.s_axis_txc_tvalid && ifc.s_axis_txc_tready) begin
                if (txc_q.size() == 0) chk("txc_unexpected", act_c, 0);
                else begin
                    e = txc_q.pop_front();
                    chk("txc_word", act_c, e);
                    if (e.d == 32'hA000_0000) txc0_cyc = cyc + 1;
                    if (e.l) want_d0 = 1;
                end
            end
            if (ifc.s_axis_txd_tvalid && ifc.s_axis_txd_tready) begin
                if (txd_q.size() == 0) chk("txd_unexpected", act_d, 0);
                else begin
                    e = txd_q.pop_front();
                    chk("txd_word", act_d, e);
                    txd_pops++;
                    if (want_d0) begin
                        txd0_cyc = cyc + 1;
                        want_d0 = 0;
                    end
                end
            end
        end
    end

    task automatic mk(input int n, input logic [31:0] seed, input logic [31:0] step,
                      input logic [3:0] lastkeep);
        beat_t b;
        in_beats.delete();
        for (int i = 0; i < n; i++) begin
            b.d = seed + step * i;
            b.l = (i == n - 1);
            b.k = b.l ? lastkeep : 4'hF;
            in_beats.push_back(b);
        end
    endtask

    task automatic send(input bit expect_tx);
        beat_t b;
        bit hs;
        int n;
        if (expect_tx) begin
            for (int i = 0; i < 6; i++) begin
                b.d = (i == 0) ? 32'hA000_0000 : 32'h0;
                b.k = 4'hF;
                b.l = (i == 5);
                txc_q.push_back(b);
            end
            foreach (in_beats[i]) txd_q.push_back(in_beats[i]);
        end
        foreach (in_beats[i]) begin
            ifc.in_tvalid = 1'b1;
            ifc.in_tdata  = in_beats[i].d;
            ifc.in_tkeep  = in_beats[i].k;
            ifc.in_tlast  = in_beats[i].l;
            n = 0;
            do begin
                @(negedge S_CLK);
                hs = ifc.in_tready;
                if (hs && in_beats[i].l) tlast_cyc = cyc + 1;
                @(posedge S_CLK);
                #1;
                n++;
            end while (!hs && n < 50);
            if (!hs) chk("in_handshake_timeout", 0, 1);
        end
        ifc.in_tvalid = 1'b0;
        ifc.in_tlast  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge S_CLK);
            n++;
        end while ((busy || txc_q.size() != 0 || txd_q.size() != 0) && n < 300);
        if (n >= 300) chk("frame_done_timeout", 0, 1);
        @(posedge S_CLK);
        #1;
    endtask

    initial begin
        int base;
        ifc.in_tvalid = 1'b0;
        ifc.in_tdata  = '0;
        ifc.in_tkeep  = '0;
        ifc.in_tlast  = 1'b0;
        ifc.s_axis_txc_tready = 1'b1;

        repeat (3) @(posedge S_CLK);
        #1;
        chk("rst_in_tready", ifc.in_tready, 0);
        chk("rst_txc_tvalid", ifc.s_axis_txc_tvalid, 0);
        chk("rst_txd_tvalid", ifc.s_axis_txd_tvalid, 0);
        chk("rst_txc_tdata", ifc.s_axis_txc_tdata, 0);
        chk("rst_txd_tdata", ifc.s_axis_txd_tdata, 0);
        chk("rst_counters", {frames_sent, frames_dropped}, 0);
        chk("rst_busy", busy, 0);
        S_ARESET = 1'b0;
        @(posedge S_CLK);
        @(negedge S_CLK);
        chk("in_tready_after_rst", ifc.in_tready, 1);
        @(posedge S_CLK);
        #1;

        // Basic 3-beat frame with latency check
        mk(3, 32'h1111_1111, 32'h1111_1111, 4'h3);
        send(1);
        wait_done();
        chk("basic_txc_latency", txc0_cyc - tlast_cyc, 1);
        chk("basic_txd_latency", txd0_cyc - tlast_cyc, 7);
        chk("basic_sent", frames_sent, 1);

        // Single-beat frame
        mk(1, 32'hDEAD_BEEF, 32'h0, 4'h1);
        send(1);
        wait_done();
        chk("single_txd_latency", txd0_cyc - tlast_cyc, 7);
        chk("single_sent", frames_sent, 2);

        // Exact fit: DEPTH words
        mk(4, 32'h0100_0001, 32'h0001_0000, 4'hF);
        send(1);
        wait_done();
        chk("exact_sent", frames_sent, 3);
        chk("exact_dropped", frames_dropped, 0);

        // Backpressure on txd
        bp_en = 1'b1;
        mk(4, 32'hA5A5_0000, 32'h0000_0101, 4'h7);
        send(1);
        wait_done();
        bp_en = 1'b0;
        repeat (2) @(posedge S_CLK);
        #1;
        chk("bp_sent", frames_sent, 4);

        // Oversize frame is dropped
        mk(6, 32'h0600_0000, 32'h1, 4'hF);
        send(0);
        repeat (10) @(posedge S_CLK);
        #1;
        chk("over_dropped", frames_dropped, 1);
        chk("over_sent", frames_sent, 4);
        chk("over_busy", busy, 0);

        mk(2, 32'h0BAD_0000, 32'h0000_1111, 4'hC);
        send(1);
        wait_done();
        chk("after_drop_sent", frames_sent, 5);

        // Reset during the txd word-2 handshake
        mk(4, 32'h4040_4040, 32'h0101_0101, 4'hF);
        base = txd_pops;
        send(1);
        for (int i = 0; i < 100 && txd_pops < base + 3; i++) begin
            @(negedge S_CLK);
            #1;
        end
        chk("mid_reached_word2", txd_pops - base, 3);
        S_ARESET = 1'b1;
        #1;
        chk("mid_rst_txd_tvalid", ifc.s_axis_txd_tvalid, 0);
        chk("mid_rst_txd_tlast", ifc.s_axis_txd_tlast, 0);
        chk("mid_rst_txc_tvalid", ifc.s_axis_txc_tvalid, 0);
        chk("mid_rst_counters", {frames_sent, frames_dropped}, 0);
        chk("mid_rst_in_tready", ifc.in_tready, 0);
        repeat (2) @(posedge S_CLK);
        #1;
        S_ARESET = 1'b0;
        @(posedge S_CLK);
        #1;

        mk(3, 32'h7000_0007, 32'h0000_0010, 4'h3);
        send(1);
        wait_done();
        chk("post_rst_sent", frames_sent, 1);
        chk("post_rst_dropped", frames_dropped, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
